// File: rtl/pc_sequencer.sv
// Fetch-address register with jump/branch redirect, trap entry/return and double-fault halt.
// Optional macro PC_MISALIGN_TRAP_EN: a redirect to a non-word-aligned target traps with cause 0.
module pc_sequencer #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100)
) (
   input  logic            i_Clock,
   input  logic            i_Reset,
   input  logic            i_Stall,
   input  logic            i_Jump,
   input  logic            i_Branch,
   input  logic [2:0]      i_BranchType,
   input  logic [XLEN-1:0] i_BranchAddress,
   input  logic            i_AluZero,
   input  logic            i_AluLessThan,
   input  logic            i_AluLessThanUnsigned,
   input  logic            i_Trap,
   input  logic [3:0]      i_TrapCause,
   input  logic            i_TrapReturn,
   output logic [XLEN-1:0] o_InstructionPointer,
   output logic [XLEN-1:0] o_Epc,
   output logic [3:0]      o_TrapCause,
   output logic            o_InHandler,
   output logic            o_Halted,
   output logic            o_Redirect
);

   // state      | meaning
   // ST_RUN     | normal fetch
   // ST_HANDLER | executing trap handler; a further trap halts
   // ST_HALTED  | double fault, frozen until reset

   localparam logic [2:0] BRANCH_EQ  = 3'b000;
   localparam logic [2:0] BRANCH_NE  = 3'b001;
   localparam logic [2:0] BRANCH_LT  = 3'b100;
   localparam logic [2:0] BRANCH_GE  = 3'b101;
   localparam logic [2:0] BRANCH_LTU = 3'b110;
   localparam logic [2:0] BRANCH_GEU = 3'b111;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HANDLER = 2'd1,
      ST_HALTED  = 2'd2
   } state_t;

   state_t          state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] epc_q;
   logic [3:0]      cause_q;
   logic            redirect_q;

   logic            branch_taken_d;
   logic            redirect_req_d;
   logic            misalign_d;
   logic            trap_req_d;
   logic [XLEN-1:0] target_d;
   logic [XLEN-1:0] pc_seq_d;

   always_comb begin
      branch_taken_d = 1'b0;
      if (i_Branch) begin
         case (i_BranchType)
            BRANCH_EQ:  branch_taken_d = i_AluZero;
            BRANCH_NE:  branch_taken_d = ~i_AluZero;
            BRANCH_LT:  branch_taken_d = i_AluLessThan;
            BRANCH_GE:  branch_taken_d = ~i_AluLessThan;
            BRANCH_LTU: branch_taken_d = i_AluLessThanUnsigned;
            BRANCH_GEU: branch_taken_d = ~i_AluLessThanUnsigned;
            default:    branch_taken_d = 1'b0;
         endcase
      end
   end

   assign redirect_req_d = i_Jump | branch_taken_d;

`ifdef PC_MISALIGN_TRAP_EN
   assign misalign_d = redirect_req_d & (i_BranchAddress[1:0] != 2'b00);
   assign target_d   = i_BranchAddress;
`else
   // Without the trap, low bits are simply dropped so fetch stays word aligned.
   assign misalign_d = 1'b0;
   assign target_d   = i_BranchAddress & ~XLEN'(3);
`endif

   assign trap_req_d = i_Trap | misalign_d;
   assign pc_seq_d   = pc_q + XLEN'(4);

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_VECTOR;
         epc_q      <= '0;
         cause_q    <= 4'd0;
         redirect_q <= 1'b0;
      end else begin
         case (state_q)
            ST_HALTED: begin
               redirect_q <= 1'b0;
            end
            default: begin
               if (trap_req_d) begin
                  if (state_q == ST_RUN) begin
                     epc_q      <= pc_q;
                     cause_q    <= i_Trap ? i_TrapCause : 4'd0;
                     pc_q       <= TRAP_VECTOR;
                     state_q    <= ST_HANDLER;
                     redirect_q <= 1'b1;
                  end else begin
                     state_q    <= ST_HALTED;
                     redirect_q <= 1'b0;
                  end
               end else if (i_Stall) begin
                  redirect_q <= 1'b0;
               end else if (i_TrapReturn && (state_q == ST_HANDLER)) begin
                  pc_q       <= epc_q;
                  state_q    <= ST_RUN;
                  redirect_q <= 1'b1;
               end else if (redirect_req_d) begin
                  pc_q       <= target_d;
                  redirect_q <= 1'b1;
               end else begin
                  pc_q       <= pc_seq_d;
                  redirect_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign o_InstructionPointer = pc_q;
   assign o_Epc                = epc_q;
   assign o_TrapCause          = cause_q;
   assign o_InHandler          = (state_q == ST_HANDLER);
   assign o_Halted             = (state_q == ST_HALTED);
   assign o_Redirect           = redirect_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector table plus randomized run against a behavioural model of pc_sequencer.
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h80;
   localparam logic [31:0] TV = 32'h100;
   localparam logic [2:0] B_EQ = 3'd0, B_NE = 3'd1, B_LT = 3'd4, B_GE = 3'd5,
                          B_LTU = 3'd6, B_GEU = 3'd7;

   typedef struct {
      logic        rst, stall, jump, branch;
      logic [2:0]  bt;
      logic [31:0] addr;
      logic [2:0]  flags;   // {zero, lt, ltu}
      logic        trap;
      logic [3:0]  cause;
      logic        ret;
      logic [31:0] e_pc;
      logic        e_redir;
      logic [1:0]  e_mode;  // 0 run, 1 handler, 2 halted
      logic [31:0] e_epc;
      logic [3:0]  e_cause;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, stall, jump, branch, zero, lt, ltu, trap, ret;
   logic [2:0]  bt;
   logic [31:0] addr;
   logic [3:0]  cause;
   logic [31:0] ip, epc;
   logic [3:0]  tcause;
   logic        in_handler, halted, redir;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_pc, m_epc;
   logic [3:0]  m_cause;
   int          m_mode;
   logic        m_redir;

   always #5 clk = ~clk;

   pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
      .i_Clock(clk), .i_Reset(rst), .i_Stall(stall), .i_Jump(jump), .i_Branch(branch),
      .i_BranchType(bt), .i_BranchAddress(addr), .i_AluZero(zero), .i_AluLessThan(lt),
      .i_AluLessThanUnsigned(ltu), .i_Trap(trap), .i_TrapCause(cause), .i_TrapReturn(ret),
      .o_InstructionPointer(ip), .o_Epc(epc), .o_TrapCause(tcause),
      .o_InHandler(in_handler), .o_Halted(halted), .o_Redirect(redir)
   );

   function automatic vec_t mk(logic r, logic s, logic j, logic b, logic [2:0] t,
                               logic [31:0] a, logic [2:0] f, logic tr, logic [3:0] c,
                               logic rt, logic [31:0] epc_, logic er, logic [1:0] em,
                               logic [31:0] eepc, logic [3:0] ec);
      vec_t v;
      v.rst = r; v.stall = s; v.jump = j; v.branch = b; v.bt = t; v.addr = a;
      v.flags = f; v.trap = tr; v.cause = c; v.ret = rt;
      v.e_pc = epc_; v.e_redir = er; v.e_mode = em; v.e_epc = eepc; v.e_cause = ec;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(vec_t v);
      bit taken, req, mis;
      logic [31:0] tgt;
      case (v.bt)
         B_EQ:    taken = v.flags[2];
         B_NE:    taken = !v.flags[2];
         B_LT:    taken = v.flags[1];
         B_GE:    taken = !v.flags[1];
         B_LTU:   taken = v.flags[0];
         B_GEU:   taken = !v.flags[0];
         default: taken = 0;
      endcase
      req = v.jump || (v.branch && taken);
`ifdef PC_MISALIGN_TRAP_EN
      mis = req && (v.addr % 4 != 0);
      tgt = v.addr;
`else
      mis = 0;
      tgt = v.addr - (v.addr % 4);
`endif
      if (v.rst) begin
         m_pc = RV; m_epc = 0; m_cause = 0; m_mode = 0; m_redir = 0;
      end else if (m_mode == 2) begin
         m_redir = 0;
      end else if (v.trap || mis) begin
         if (m_mode == 0) begin
            m_epc = m_pc; m_cause = v.trap ? v.cause : 4'd0;
            m_pc = TV; m_mode = 1; m_redir = 1;
         end else begin
            m_mode = 2; m_redir = 0;
         end
      end else if (v.stall) begin
         m_redir = 0;
      end else if (v.ret && m_mode == 1) begin
         m_pc = m_epc; m_mode = 0; m_redir = 1;
      end else if (req) begin
         m_pc = tgt; m_redir = 1;
      end else begin
         m_pc = m_pc + 32'd4; m_redir = 0;
      end
   endtask

   task automatic step(vec_t v, bit use_exp);
      rst = v.rst; stall = v.stall; jump = v.jump; branch = v.branch; bt = v.bt;
      addr = v.addr; {zero, lt, ltu} = v.flags; trap = v.trap; cause = v.cause; ret = v.ret;
      model_step(v);
      @(posedge clk);
      #1;
      chk("model_pc", ip, m_pc);
      chk("model_epc", epc, m_epc);
      chk("model_cause", {28'd0, tcause}, {28'd0, m_cause});
      chk("model_handler", {31'd0, in_handler}, {31'd0, m_mode == 1});
      chk("model_halted", {31'd0, halted}, {31'd0, m_mode == 2});
      chk("model_redirect", {31'd0, redir}, {31'd0, m_redir});
      if (use_exp) begin
         chk("vec_pc", ip, v.e_pc);
         chk("vec_redirect", {31'd0, redir}, {31'd0, v.e_redir});
         chk("vec_mode", {30'd0, halted, in_handler}, {30'd0, v.e_mode});
         chk("vec_epc", epc, v.e_epc);
         chk("vec_cause", {28'd0, tcause}, {28'd0, v.e_cause});
      end
   endtask

   initial begin
      vec_t tbl[$];
      vec_t v;
      rst = 1; stall = 0; jump = 0; branch = 0; bt = 0; addr = 0;
      zero = 0; lt = 0; ltu = 0; trap = 0; cause = 0; ret = 0;

      //            r  s  j  b  bt     addr          flags  tr c  rt  pc            rd md epc    cause
      tbl.push_back(mk(1, 0, 0, 0, 0,     0,            0,     0, 0, 0, 32'h80,       0, 0, 0,     0));
      tbl.push_back(mk(0, 0, 0, 0, 0,     0,            0,     0, 0, 0, 32'h84,       0, 0, 0,     0));
      tbl.push_back(mk(0, 0, 0, 0, 0,     0,            0,     0, 0, 0, 32'h88,       0, 0, 0,     0));
      tbl.push_back(mk(0, 0, 0, 0, 0,     0,            0,     0, 0, 0, 32'h8C,       0, 0, 0,     0));
      tbl.push_back(mk(0, 0, 0, 1, B_LT,  32'h40,       3'b010, 0, 0, 0, 32'h40,      1, 0, 0,     0));
      tbl.push_back(mk(0, 0, 0, 1, B_LT,  32'h200,      3'b000, 0, 0, 0, 32'h44,      0, 0, 0,     0));
      tbl.push_back(mk(0, 0, 1, 0, 0,     32'h20,       0,     0, 0, 0, 32'h20,       1, 0, 0,     0));
      tbl.push_back(mk(0, 0, 0, 0, 0,     0,            0,     1, 7, 0, 32'h100,      1, 1, 32'h20, 7));
      tbl.push_back(mk(0, 0, 0, 0, 0,     0,            0,     0, 0, 0, 32'h104,      0, 1, 32'h20, 7));
      tbl.push_back(mk(0, 0, 1, 0, 0,     32'h300,      0,     0, 0, 0, 32'h300,      1, 1, 32'h20, 7));
      tbl.push_back(mk(0, 0, 1, 0, 0,     32'h500,      0,     0, 0, 1, 32'h20,       1, 0, 32'h20, 7));
      tbl.push_back(mk(0, 0, 0, 0, 0,     0,            0,     0, 0, 1, 32'h24,       0, 0, 32'h20, 7));
      tbl.push_back(mk(0, 1, 1, 0, 0,     32'h600,      0,     0, 0, 0, 32'h24,       0, 0, 32'h20, 7));
      tbl.push_back(mk(0, 1, 1, 0, 0,     32'h600,      0,     0, 0, 0, 32'h24,       0, 0, 32'h20, 7));
      tbl.push_back(mk(0, 1, 1, 0, 0,     32'h600,      0,     0, 0, 0, 32'h24,       0, 0, 32'h20, 7));
      tbl.push_back(mk(0, 1, 0, 0, 0,     0,            0,     1, 3, 0, 32'h100,      1, 1, 32'h24, 3));
      tbl.push_back(mk(0, 0, 0, 0, 0,     0,            0,     1, 5, 0, 32'h100,      0, 2, 32'h24, 3));
      for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

      // double fault: frozen for 10 cycles despite jumps, traps and returns
      for (int i = 0; i < 10; i++) begin
         v = mk(0, 0, 1, 0, 0, 32'h700 + 32'(i * 4), 0, i[0], 4'd9, 1, 32'h100, 0, 2, 32'h24, 3);
         step(v, 1'b1);
      end

      tbl.delete();
      tbl.push_back(mk(1, 0, 1, 0, 0,     32'h700,      0,     0, 0, 0, 32'h80,       0, 0, 0,     0));
      tbl.push_back(mk(0, 0, 0, 1, B_EQ,  32'h10,       3'b100, 0, 0, 0, 32'h10,      1, 0, 0,     0));
      tbl.push_back(mk(0, 0, 0, 1, B_NE,  32'h30,       3'b100, 0, 0, 0, 32'h14,      0, 0, 0,     0));
      tbl.push_back(mk(0, 0, 0, 1, B_GEU, 32'h30,       3'b000, 0, 0, 0, 32'h30,      1, 0, 0,     0));
      tbl.push_back(mk(0, 0, 0, 1, 3'd2,  32'h50,       3'b111, 0, 0, 0, 32'h34,      0, 0, 0,     0));
      tbl.push_back(mk(0, 0, 0, 1, B_GE,  32'h60,       3'b101, 0, 0, 0, 32'h60,      1, 0, 0,     0));
      tbl.push_back(mk(0, 0, 0, 1, B_LTU, 32'h70,       3'b001, 0, 0, 0, 32'h70,      1, 0, 0,     0));
      tbl.push_back(mk(0, 0, 1, 0, 0,     32'hFFFFFFFC, 0,     0, 0, 0, 32'hFFFFFFFC, 1, 0, 0,     0));
      tbl.push_back(mk(0, 0, 0, 0, 0,     0,            0,     0, 0, 0, 32'h0,        0, 0, 0,     0));
      tbl.push_back(mk(0, 0, 0, 0, 0,     0,            0,     0, 0, 0, 32'h4,        0, 0, 0,     0));
`ifdef PC_MISALIGN_TRAP_EN
      tbl.push_back(mk(0, 0, 1, 0, 0,     32'h42,       0,     0, 0, 0, 32'h100,      1, 1, 32'h4, 0));
`else
      tbl.push_back(mk(0, 0, 1, 0, 0,     32'h42,       0,     0, 0, 0, 32'h40,       1, 0, 0,     0));
`endif
      for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

      // randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         v.rst    = ($urandom_range(0, 99) < 2);
         v.stall  = ($urandom_range(0, 5) == 0);
         v.jump   = ($urandom_range(0, 7) == 0);
         v.branch = ($urandom_range(0, 3) == 0);
         v.bt     = 3'($urandom_range(0, 7));
         v.addr   = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255)) << 2;
         v.flags  = 3'($urandom_range(0, 7));
         v.trap   = ($urandom_range(0, 24) == 0);
         v.cause  = 4'($urandom_range(0, 15));
         v.ret    = ($urandom_range(0, 5) == 0);
         step(v, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
